// File: rtl/fc_layer_sequencer_if.sv
// Datapath-side bus between the dense-layer sequencer and the memories, MAC and quantizer.
// The sequencer drives through master; the datapath answers quant_ok through slave.
interface fc_layer_sequencer_if #(
    parameter int FEAT_AW = 10,
    parameter int WGT_AW  = 13,
    parameter int RES_AW  = 4
);
    logic               mem_rd_en;
    logic [FEAT_AW-1:0] feat_addr;
    logic [WGT_AW-1:0]  wgt_addr;
    logic               mac_clr;
    logic               mac_en;
    logic               mac_last;
    logic               quant_start;
    logic               quant_ok;
    logic               res_we;
    logic [RES_AW-1:0]  res_addr;

    modport master (
        output mem_rd_en, feat_addr, wgt_addr,
        output mac_clr, mac_en, mac_last,
        output quant_start, res_we, res_addr,
        input  quant_ok
    );

    modport slave (
        input  mem_rd_en, feat_addr, wgt_addr,
        input  mac_clr, mac_en, mac_last,
        input  quant_start, res_we, res_addr,
        output quant_ok
    );
endinterface

// File: rtl/fc_layer_sequencer.sv
// Walks every output neuron of the dense layer: clear, stream feature/weight reads,
// drain the MAC pipeline, run the quantizer and store one result per neuron.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | accumulator clear pulse
// FETCH  | NUM_IN feature/weight reads
// DRAIN  | RD_LAT+MAC_LAT cycles for the last product to settle
// QSTART | quantizer launch pulse
// QWAIT  | waiting for quant_ok, bounded by TIMEOUT
// WRITE  | result write for neuron n
// DONE   | completion pulse
module fc_layer_sequencer #(
    parameter int NUM_IN  = 507,
    parameter int NUM_OUT = 10,
    parameter int RD_LAT  = 1,
    parameter int MAC_LAT = 2,
    parameter int TIMEOUT = 255,
    parameter int FEAT_AW = 10,
    parameter int WGT_AW  = 13,
    parameter int RES_AW  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic err,
    fc_layer_sequencer_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_QSTART = 3'd4;
    localparam logic [2:0] S_QWAIT  = 3'd5;
    localparam logic [2:0] S_WRITE  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam int DRAIN_LEN = RD_LAT + MAC_LAT;
    localparam int T_MAX     = (TIMEOUT > DRAIN_LEN) ? TIMEOUT : DRAIN_LEN;
    localparam int TW        = $clog2(T_MAX + 1);

    localparam logic [TW-1:0]      DRAIN_LOAD = TW'(DRAIN_LEN - 1);
    localparam logic [TW-1:0]      QWAIT_LOAD = TW'(TIMEOUT - 1);
    localparam logic [FEAT_AW-1:0] LAST_I     = FEAT_AW'(NUM_IN - 1);
    localparam logic [FEAT_AW-1:0] PENULT_I   = FEAT_AW'((NUM_IN > 1) ? NUM_IN - 2 : 0);
    localparam logic [RES_AW-1:0]  LAST_N     = RES_AW'(NUM_OUT - 1);
    localparam logic [WGT_AW-1:0]  WGT_STEP   = WGT_AW'(NUM_IN);

    logic [2:0]         state;
    logic [TW-1:0]      timer;
    logic [WGT_AW-1:0]  wgt_base;
    logic               mem_rd_en;
    logic               rd_last;
    logic [FEAT_AW-1:0] feat_addr;
    logic [WGT_AW-1:0]  wgt_addr;
    logic               mac_clr;
    logic               quant_start;
    logic               res_we;
    logic [RES_AW-1:0]  n_idx;
    logic [RD_LAT-1:0]  en_pipe;
    logic [RD_LAT-1:0]  last_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            wgt_base    <= '0;
            mem_rd_en   <= 1'b0;
            rd_last     <= 1'b0;
            feat_addr   <= '0;
            wgt_addr    <= '0;
            mac_clr     <= 1'b0;
            quant_start <= 1'b0;
            res_we      <= 1'b0;
            n_idx       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            mem_rd_en   <= 1'b0;
            rd_last     <= 1'b0;
            mac_clr     <= 1'b0;
            quant_start <= 1'b0;
            res_we      <= 1'b0;
            done        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_CLEAR;
                        n_idx    <= '0;
                        wgt_base <= '0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        mac_clr  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state     <= S_FETCH;
                    mem_rd_en <= 1'b1;
                    rd_last   <= (NUM_IN == 1);
                    feat_addr <= '0;
                    wgt_addr  <= wgt_base;
                end
                S_FETCH: begin
                    if (feat_addr == LAST_I) begin
                        state <= S_DRAIN;
                        timer <= DRAIN_LOAD;
                    end else begin
                        mem_rd_en <= 1'b1;
                        rd_last   <= (feat_addr == PENULT_I);
                        feat_addr <= feat_addr + 1'b1;
                        wgt_addr  <= wgt_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (timer == '0) begin
                        state       <= S_QSTART;
                        quant_start <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_QSTART: begin
                    state <= S_QWAIT;
                    timer <= QWAIT_LOAD;
                end
                // quant_ok is only honoured here, so stray pulses elsewhere are harmless
                S_QWAIT: begin
                    if (bus.quant_ok) begin
                        state  <= S_WRITE;
                        res_we <= 1'b1;
                    end else if (timer == '0) begin
                        state <= S_DONE;
                        err   <= 1'b1;
                        done  <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_WRITE: begin
                    if (n_idx == LAST_N) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= S_CLEAR;
                        n_idx    <= n_idx + 1'b1;
                        wgt_base <= wgt_base + WGT_STEP;
                        mac_clr  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read strobe delayed by the memory latency marks when product data is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_pipe   <= '0;
            last_pipe <= '0;
        end else begin
            en_pipe[0]   <= mem_rd_en;
            last_pipe[0] <= rd_last;
            for (int k = 1; k < RD_LAT; k++) begin
                en_pipe[k]   <= en_pipe[k-1];
                last_pipe[k] <= last_pipe[k-1];
            end
        end
    end

    assign bus.mem_rd_en   = mem_rd_en;
    assign bus.feat_addr   = feat_addr;
    assign bus.wgt_addr    = wgt_addr;
    assign bus.mac_clr     = mac_clr;
    assign bus.mac_en      = en_pipe[RD_LAT-1];
    assign bus.mac_last    = last_pipe[RD_LAT-1];
    assign bus.quant_start = quant_start;
    assign bus.res_we      = res_we;
    assign bus.res_addr    = n_idx;
endmodule
